// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with the operand-forwarding network that feeds the
//   main ALU and the store-data path. It also raises the load-use hazard
//   request to the hazard unit.
//
// Ports
//   i_clk, i_rst                 clock (rising edge), synchronous active-high reset
//   i_stall, i_flush             hold stage / insert bubble (flush wins)
//   i_id_*                       decoded instruction state from ID
//   i_mem_reg_write/rd/result    MEM-stage producer (highest forwarding priority)
//   i_wb_reg_write/rd/result     WB-stage producer
//   o_op_a, o_op_b, o_alu_op     ALU operands and control
//   o_store_data                 forwarded rs2 for stores
//   o_pc, o_rd_addr              registered PC and destination
//   o_ex_valid, o_reg_write,
//   o_mem_read, o_mem_write,
//   o_branch                     registered control (all 0 when not valid)
//   o_load_use_hazard            combinational stall request
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_id_valid,
    input  logic [DATA_W-1:0]     i_id_pc,
    input  logic [DATA_W-1:0]     i_id_rs1_data,
    input  logic [DATA_W-1:0]     i_id_rs2_data,
    input  logic [DATA_W-1:0]     i_id_imm,
    input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] i_id_rd_addr,
    input  logic [2:0]            i_id_alu_op,
    input  logic                  i_id_alu_src_a,
    input  logic                  i_id_alu_src_b,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_mem_read,
    input  logic                  i_id_mem_write,
    input  logic                  i_id_branch,
    input  logic                  i_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
    input  logic [DATA_W-1:0]     i_mem_result,
    input  logic                  i_wb_reg_write,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
    input  logic [DATA_W-1:0]     i_wb_result,
    output logic [DATA_W-1:0]     o_op_a,
    output logic [DATA_W-1:0]     o_op_b,
    output logic [2:0]            o_alu_op,
    output logic [DATA_W-1:0]     o_store_data,
    output logic [DATA_W-1:0]     o_pc,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic                  o_ex_valid,
    output logic                  o_reg_write,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_branch,
    output logic                  o_load_use_hazard
);

    // ALU control encoding for add (bubble / reset opcode).
    localparam logic [2:0] ALU_CTL_ADD = 3'b010;

    logic                  valid_q,     valid_d;
    logic [DATA_W-1:0]     pc_q,        pc_d;
    logic [DATA_W-1:0]     rs1_data_q,  rs1_data_d;
    logic [DATA_W-1:0]     rs2_data_q,  rs2_data_d;
    logic [DATA_W-1:0]     imm_q,       imm_d;
    logic [REG_ADDR_W-1:0] rs1_addr_q,  rs1_addr_d;
    logic [REG_ADDR_W-1:0] rs2_addr_q,  rs2_addr_d;
    logic [REG_ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [2:0]            alu_op_q,    alu_op_d;
    logic                  src_a_q,     src_a_d;
    logic                  src_b_q,     src_b_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_read_q,  mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  branch_q,    branch_d;

    logic [DATA_W-1:0]     fwd_rs1;
    logic [DATA_W-1:0]     fwd_rs2;

    // MEM beats WB; x0 is never forwarded so its registered data passes through.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [DATA_W-1:0]     reg_data,
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic [DATA_W-1:0]     mem_res,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [DATA_W-1:0]     wb_res
    );
        logic [DATA_W-1:0] r;
        r = reg_data;
        if (addr != '0) begin
            if (mem_we && (mem_rd == addr)) begin
                r = mem_res;
            end else if (wb_we && (wb_rd == addr)) begin
                r = wb_res;
            end
        end
        return r;
    endfunction

    always_comb begin
        fwd_rs1 = fwd_sel(rs1_addr_q, rs1_data_q, i_mem_reg_write, i_mem_rd_addr,
                          i_mem_result, i_wb_reg_write, i_wb_rd_addr, i_wb_result);
        fwd_rs2 = fwd_sel(rs2_addr_q, rs2_data_q, i_mem_reg_write, i_mem_rd_addr,
                          i_mem_result, i_wb_reg_write, i_wb_rd_addr, i_wb_result);
    end

    // Next-state: flush > stall > load. Reset is applied in the register block.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        alu_op_d    = alu_op_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        branch_d    = branch_q;

        if (i_flush) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
            rs1_addr_d  = '0;
            rs2_addr_d  = '0;
            rd_addr_d   = '0;
            alu_op_d    = ALU_CTL_ADD;
            src_a_d     = 1'b0;
            src_b_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            branch_d    = 1'b0;
        end else if (i_stall) begin
            // Re-capture forwarded operands so producers that retire from
            // MEM/WB during the stall are not lost.
            rs1_data_d  = fwd_rs1;
            rs2_data_d  = fwd_rs2;
        end else begin
            valid_d     = i_id_valid;
            pc_d        = i_id_pc;
            rs1_data_d  = i_id_rs1_data;
            rs2_data_d  = i_id_rs2_data;
            imm_d       = i_id_imm;
            rs1_addr_d  = i_id_rs1_addr;
            rs2_addr_d  = i_id_rs2_addr;
            rd_addr_d   = i_id_rd_addr;
            alu_op_d    = i_id_alu_op;
            src_a_d     = i_id_alu_src_a;
            src_b_d     = i_id_alu_src_b;
            // Side-effect controls are qualified by valid at capture so an
            // invalid slot can never write, read or branch.
            reg_write_d = i_id_reg_write & i_id_valid;
            mem_read_d  = i_id_mem_read  & i_id_valid;
            mem_write_d = i_id_mem_write & i_id_valid;
            branch_d    = i_id_branch    & i_id_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            alu_op_q    <= ALU_CTL_ADD;
            src_a_q     <= 1'b0;
            src_b_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            alu_op_q    <= alu_op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            branch_q    <= branch_d;
        end
    end

    assign o_op_a       = src_a_q ? pc_q  : fwd_rs1;
    assign o_op_b       = src_b_q ? imm_q : fwd_rs2;
    assign o_store_data = fwd_rs2;
    assign o_alu_op     = alu_op_q;
    assign o_pc         = pc_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_ex_valid   = valid_q;
    assign o_reg_write  = reg_write_q;
    assign o_mem_read   = mem_read_q;
    assign o_mem_write  = mem_write_q;
    assign o_branch     = branch_q;

    // A load in EX whose destination is read by the instruction in ID cannot
    // be forwarded in time; ask the hazard unit for a one-cycle bubble.
    assign o_load_use_hazard = valid_q & mem_read_q & (rd_addr_q != '0) & i_id_valid &
                               ((rd_addr_q == i_id_rs1_addr) | (rd_addr_q == i_id_rs2_addr));

endmodule
